qbu_rx_demux: RTL and testbench
===============================

// Module: qbu_rx_demux
// PURPOSE
//  RX-side counterpart of the Qbu TX mux. Classifies each received mPacket by its SMD and routes it.
//  SMD-E frames go to the eMAC path; SMD-S/SMD-C fragments go to the pMAC path with per-frame
//  fragment-count tracking; SMD-V/SMD-R frames go to the verify handshake. Invalid traffic is dropped.
//  Sits between the RX MAC deframer (preamble/CRC checker) and the eMAC/pMAC receive logic.
// PARAMETERS
//  AXIS_DATA_WIDTH  8  beat width in bits; byte count per beat = AXIS_DATA_WIDTH/8
// PORTS
//  i_clk              in   1   clock
//  i_rst              in   1   reset, asynchronous, active-high
//  i_mac_rx_data      in   W   mPacket payload beat, preamble and SMD stripped
//  i_mac_rx_valid     in   1   beat valid
//  i_mac_rx_last      in   1   last beat of mPacket
//  o_mac_rx_ready     out  1   beat accepted when valid&ready
//  i_mac_rx_smd       in   8   SMD; sampled on the first beat only
//  i_mac_rx_smd_vld   in   1   marks the first beat of an mPacket
//  i_mac_rx_fra       in   8   frag_count octet; valid with smd_vld for SMD-C
//  i_mac_rx_fra_vld   in   1   frag_count present
//  i_mac_rx_crc_ok    in   1   on the last beat: trailing 4 bytes match the normal CRC
//  i_mac_rx_mcrc      in   1   on the last beat: trailing 4 bytes match the mCRC (more fragments follow)
//  i_preempt_en       in   1   verification succeeded; preemption enabled
//  o_emac_rx_data/valid/last/err  out  W/1/1/1  express stream; err=1 on last when CRC bad
//  i_emac_rx_ready    in   1   express stream ready
//  o_pmac_rx_data/valid/last/err  out  W/1/1/1  preemptable stream; last only on the final fragment
//  o_pmac_rx_abort    out  1   1-cycle pulse: discard the partially received preemptable frame
//  i_pmac_rx_ready    in   1   preemptable stream ready
//  o_verify_rcv       out  1   1-cycle pulse: valid SMD-V frame received
//  o_respond_rcv      out  1   1-cycle pulse: valid SMD-R frame received
//  o_pre_active       out  1   preemptable frame in progress, awaiting continuation
//  o_smd_err_cnt      out  16  saturating count of unknown/disallowed SMDs
//  o_frag_err_cnt     out  16  saturating count of fragment sequence errors
// BEHAVIOUR
//  Reset: all outputs, counters, state and context cleared to 0; FSM = IDLE.
//  SMD codes: E=D5, V=07, R=19, S0..S3=E6,4C,7F,B3, C0..C3=61,52,2A,9E.
//    frag_count codes 0..3 = E6,4C,7F,B3.
//  Output stages are registered, latency 1 cycle. Each path holds its data while valid&!ready.
//  o_mac_rx_ready:
//    IDLE: both output stages free (!vld||rdy).
//    EXP: emac stage free. PRE: pmac stage free. VERIFY/DROP: 1.
//  FSM, decided on the accepted first beat (smd_vld=1). That beat is forwarded/consumed in the new state.
//   IDLE, first beat, smd_vld=0 -> DROP; o_smd_err_cnt++.
//   SMD-E -> EXP. Legal in any mode. Does not disturb the pMAC context (express preemption).
//   SMD-V/R -> VERIFY. Legal regardless of i_preempt_en.
//   SMD-Sx, preempt_en=1 -> PRE.
//     If pre_active: pulse abort and frag_err_cnt++.
//     Then sc<=x, frag_exp<=0, pre_active<=1.
//   SMD-Cx, preempt_en=1 -> PRE only if all hold: pre_active, x==sc, fra_vld, fra==code(frag_exp).
//     Otherwise DROP, frag_err_cnt++. If pre_active was set: pulse abort, pre_active<=0.
//   Unknown SMD, or S/C with preempt_en=0 -> DROP; smd_err_cnt++.
//  Last beat, by state:
//   EXP: emac last=1, err=!crc_ok.
//   PRE, mcrc=1: no pmac last; frag_exp<=frag_exp+1 mod 4; pre_active stays 1.
//   PRE, crc_ok=1: pmac last=1, err=0, pre_active<=0.
//   PRE, neither: pmac last=1, err=1, pre_active<=0.
//   VERIFY: pulse verify_rcv (V) or respond_rcv (R) only if crc_ok and byte count == 60.
//   DROP: discarded.
//   All states return to IDLE.
//  Byte counter in VERIFY is 7-bit and saturates at 127.
//  smd_vld on a non-first beat is ignored. Simultaneous abort and new S start in one cycle is legal.
//  i_preempt_en falling while pre_active: pulse abort, pre_active<=0; current frame continues.
// TESTING
//  E frame, 64B, crc_ok -> 64 beats on emac, last on beat 64, err=0; pmac idle.
//  S1 mcrc, E frame, C1 fra=4C crc_ok -> express frame forwarded between fragments.
//    pmac gets both fragments and one last; pre_active 1->0.
//  S0 mcrc, then C0 fra=7F -> DROP, abort pulse, frag_err_cnt=1, pre_active=0.
//  V frame 60B crc_ok -> verify_rcv pulse 1 cycle. R frame 59B -> no pulse.
//  preempt_en=0, S0 frame -> dropped, smd_err_cnt=1. E frame with i_emac_rx_ready low 10 cycles
//    -> o_mac_rx_ready low, no beat lost.
//  i_rst asserted mid-PRE fragment -> all outputs 0, next C frame dropped with frag_err_cnt=1.

Source files
------------

// File: rtl/qbu_rx_demux.sv
// Qbu RX demux: classifies received mPackets by SMD and routes them
// to the eMAC, pMAC or verify paths, and tracks the fragment sequence.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_mac_rx_*          beats from the RX deframer (SMD, frag_count, CRC flags)
//   o_mac_rx_ready      beat accept
//   i_preempt_en        preemption enabled after verification
//   o_emac_rx_*         express stream (registered)
//   o_pmac_rx_*         preemptable stream, plus abort pulse (registered)
//   o_verify_rcv        valid SMD-V frame pulse
//   o_respond_rcv       valid SMD-R frame pulse
//   o_pre_active        preemptable frame awaiting continuation
//   o_smd_err_cnt       saturating count of bad SMDs
//   o_frag_err_cnt      saturating count of fragment sequence errors
module qbu_rx_demux #(
  parameter int AXIS_DATA_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [AXIS_DATA_WIDTH-1:0] i_mac_rx_data,
  input  logic                       i_mac_rx_valid,
  input  logic                       i_mac_rx_last,
  output logic                       o_mac_rx_ready,
  input  logic [7:0]                 i_mac_rx_smd,
  input  logic                       i_mac_rx_smd_vld,
  input  logic [7:0]                 i_mac_rx_fra,
  input  logic                       i_mac_rx_fra_vld,
  input  logic                       i_mac_rx_crc_ok,
  input  logic                       i_mac_rx_mcrc,
  input  logic                       i_preempt_en,
  output logic [AXIS_DATA_WIDTH-1:0] o_emac_rx_data,
  output logic                       o_emac_rx_valid,
  output logic                       o_emac_rx_last,
  output logic                       o_emac_rx_err,
  input  logic                       i_emac_rx_ready,
  output logic [AXIS_DATA_WIDTH-1:0] o_pmac_rx_data,
  output logic                       o_pmac_rx_valid,
  output logic                       o_pmac_rx_last,
  output logic                       o_pmac_rx_err,
  output logic                       o_pmac_rx_abort,
  input  logic                       i_pmac_rx_ready,
  output logic                       o_verify_rcv,
  output logic                       o_respond_rcv,
  output logic                       o_pre_active,
  output logic [15:0]                o_smd_err_cnt,
  output logic [15:0]                o_frag_err_cnt
);

  localparam int W   = AXIS_DATA_WIDTH;
  localparam int BPB = AXIS_DATA_WIDTH / 8;

  localparam logic [7:0] SMD_E = 8'hD5;
  localparam logic [7:0] SMD_V = 8'h07;
  localparam logic [7:0] SMD_R = 8'h19;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXP,
    S_PRE,
    S_VER,
    S_DROP
  } st_t;

  function automatic logic [7:0] fcode(input logic [1:0] idx);
    case (idx)
      2'd0:    fcode = 8'hE6;
      2'd1:    fcode = 8'h4C;
      2'd2:    fcode = 8'h7F;
      default: fcode = 8'hB3;
    endcase
  endfunction

  st_t            state_q, state_d, eff;
  logic           emac_vld_q, emac_vld_d;
  logic [W-1:0]   emac_data_q, emac_data_d;
  logic           emac_last_q, emac_last_d;
  logic           emac_err_q, emac_err_d;
  logic           pmac_vld_q, pmac_vld_d;
  logic [W-1:0]   pmac_data_q, pmac_data_d;
  logic           pmac_last_q, pmac_last_d;
  logic           pmac_err_q, pmac_err_d;
  logic           abort_q, abort_d;
  logic           ver_q, ver_d;
  logic           rsp_q, rsp_d;
  logic           pre_act_q, pre_act_d;
  logic [1:0]     sc_q, sc_d;
  logic [1:0]     fexp_q, fexp_d;
  logic           vkind_q, vkind_d;
  logic [6:0]     bcnt_q, bcnt_d;
  logic [15:0]    smd_cnt_q, smd_cnt_d;
  logic [15:0]    frag_cnt_q, frag_cnt_d;

  logic           emac_free, pmac_free;
  logic           rdy, acc, sv;
  logic           is_s, is_c;
  logic [1:0]     s_idx, c_idx;
  logic           smd_inc, frag_inc;
  logic [6:0]     bbase, bsum;
  logic [7:0]     bsum_w;

  assign emac_free = !emac_vld_q || i_emac_rx_ready;
  assign pmac_free = !pmac_vld_q || i_pmac_rx_ready;
  assign sv        = i_mac_rx_smd_vld;

  always_comb begin
    rdy = 1'b1;
    unique case (state_q)
      S_IDLE:  rdy = emac_free && pmac_free;
      S_EXP:   rdy = emac_free;
      S_PRE:   rdy = pmac_free;
      default: rdy = 1'b1;
    endcase
  end

  assign acc = i_mac_rx_valid && rdy;

  always_comb begin
    is_s  = 1'b0;
    s_idx = 2'd0;
    case (i_mac_rx_smd)
      8'hE6:   begin is_s = 1'b1; s_idx = 2'd0; end
      8'h4C:   begin is_s = 1'b1; s_idx = 2'd1; end
      8'h7F:   begin is_s = 1'b1; s_idx = 2'd2; end
      8'hB3:   begin is_s = 1'b1; s_idx = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    is_c  = 1'b0;
    c_idx = 2'd0;
    case (i_mac_rx_smd)
      8'h61:   begin is_c = 1'b1; c_idx = 2'd0; end
      8'h52:   begin is_c = 1'b1; c_idx = 2'd1; end
      8'h2A:   begin is_c = 1'b1; c_idx = 2'd2; end
      8'h9E:   begin is_c = 1'b1; c_idx = 2'd3; end
      default: ;
    endcase
  end

  // Verify byte count restarts on the first beat and sticks at 127.
  assign bbase  = (state_q == S_IDLE) ? 7'd0 : bcnt_q;
  assign bsum_w = {1'b0, bbase} + 8'(BPB);
  assign bsum   = (bsum_w > 8'd127) ? 7'd127 : bsum_w[6:0];

  always_comb begin
    state_d     = state_q;
    emac_vld_d  = emac_vld_q && !i_emac_rx_ready;
    emac_data_d = emac_data_q;
    emac_last_d = emac_last_q;
    emac_err_d  = emac_err_q;
    pmac_vld_d  = pmac_vld_q && !i_pmac_rx_ready;
    pmac_data_d = pmac_data_q;
    pmac_last_d = pmac_last_q;
    pmac_err_d  = pmac_err_q;
    abort_d     = 1'b0;
    ver_d       = 1'b0;
    rsp_d       = 1'b0;
    pre_act_d   = pre_act_q;
    sc_d        = sc_q;
    fexp_d      = fexp_q;
    vkind_d     = vkind_q;
    bcnt_d      = bcnt_q;
    smd_inc     = 1'b0;
    frag_inc    = 1'b0;
    eff         = state_q;

    if (acc && state_q == S_IDLE) begin
      eff = S_DROP;
      unique case (1'b1)
        !sv: smd_inc = 1'b1;
        sv && i_mac_rx_smd == SMD_E: eff = S_EXP;
        sv && (i_mac_rx_smd == SMD_V ||
               i_mac_rx_smd == SMD_R): begin
          eff     = S_VER;
          vkind_d = (i_mac_rx_smd == SMD_R);
        end
        sv && is_s && i_preempt_en: begin
          eff = S_PRE;
          if (pre_act_q) begin
            abort_d  = 1'b1;
            frag_inc = 1'b1;
          end
          sc_d      = s_idx;
          fexp_d    = 2'd0;
          pre_act_d = 1'b1;
        end
        sv && is_c && i_preempt_en: begin
          if (pre_act_q && c_idx == sc_q &&
              i_mac_rx_fra_vld &&
              i_mac_rx_fra == fcode(fexp_q)) begin
            eff = S_PRE;
          end else begin
            frag_inc = 1'b1;
            if (pre_act_q) begin
              abort_d   = 1'b1;
              pre_act_d = 1'b0;
            end
          end
        end
        default: smd_inc = 1'b1;
      endcase
    end

    if (acc) begin
      unique case (eff)
        S_EXP: begin
          emac_vld_d  = 1'b1;
          emac_data_d = i_mac_rx_data;
          emac_last_d = i_mac_rx_last;
          emac_err_d  = i_mac_rx_last && !i_mac_rx_crc_ok;
        end
        S_PRE: begin
          // mCRC ends a fragment, not the frame.
          pmac_vld_d  = 1'b1;
          pmac_data_d = i_mac_rx_data;
          pmac_last_d = i_mac_rx_last && !i_mac_rx_mcrc;
          pmac_err_d  = i_mac_rx_last && !i_mac_rx_mcrc &&
                        !i_mac_rx_crc_ok;
          if (i_mac_rx_last) begin
            if (i_mac_rx_mcrc) fexp_d = fexp_d + 2'd1;
            else               pre_act_d = 1'b0;
          end
        end
        S_VER: begin
          bcnt_d = bsum;
          if (i_mac_rx_last && i_mac_rx_crc_ok &&
              bsum == 7'd60) begin
            if (vkind_d) rsp_d = 1'b1;
            else         ver_d = 1'b1;
          end
        end
        default: ;
      endcase
      state_d = i_mac_rx_last ? S_IDLE : eff;
    end

    // Losing preemption abandons the pMAC frame; the current beat stream continues.
    if (!i_preempt_en && pre_act_q) begin
      abort_d   = 1'b1;
      pre_act_d = 1'b0;
    end

    smd_cnt_d  = smd_cnt_q;
    frag_cnt_d = frag_cnt_q;
    if (smd_inc && smd_cnt_q != 16'hFFFF)
      smd_cnt_d = smd_cnt_q + 16'd1;
    if (frag_inc && frag_cnt_q != 16'hFFFF)
      frag_cnt_d = frag_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      emac_vld_q  <= 1'b0;
      emac_data_q <= '0;
      emac_last_q <= 1'b0;
      emac_err_q  <= 1'b0;
      pmac_vld_q  <= 1'b0;
      pmac_data_q <= '0;
      pmac_last_q <= 1'b0;
      pmac_err_q  <= 1'b0;
      abort_q     <= 1'b0;
      ver_q       <= 1'b0;
      rsp_q       <= 1'b0;
      pre_act_q   <= 1'b0;
      sc_q        <= 2'd0;
      fexp_q      <= 2'd0;
      vkind_q     <= 1'b0;
      bcnt_q      <= 7'd0;
      smd_cnt_q   <= 16'd0;
      frag_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      emac_vld_q  <= emac_vld_d;
      emac_data_q <= emac_data_d;
      emac_last_q <= emac_last_d;
      emac_err_q  <= emac_err_d;
      pmac_vld_q  <= pmac_vld_d;
      pmac_data_q <= pmac_data_d;
      pmac_last_q <= pmac_last_d;
      pmac_err_q  <= pmac_err_d;
      abort_q     <= abort_d;
      ver_q       <= ver_d;
      rsp_q       <= rsp_d;
      pre_act_q   <= pre_act_d;
      sc_q        <= sc_d;
      fexp_q      <= fexp_d;
      vkind_q     <= vkind_d;
      bcnt_q      <= bcnt_d;
      smd_cnt_q   <= smd_cnt_d;
      frag_cnt_q  <= frag_cnt_d;
    end
  end

  assign o_mac_rx_ready  = rdy;
  assign o_emac_rx_data  = emac_data_q;
  assign o_emac_rx_valid = emac_vld_q;
  assign o_emac_rx_last  = emac_last_q;
  assign o_emac_rx_err   = emac_err_q;
  assign o_pmac_rx_data  = pmac_data_q;
  assign o_pmac_rx_valid = pmac_vld_q;
  assign o_pmac_rx_last  = pmac_last_q;
  assign o_pmac_rx_err   = pmac_err_q;
  assign o_pmac_rx_abort = abort_q;
  assign o_verify_rcv    = ver_q;
  assign o_respond_rcv   = rsp_q;
  assign o_pre_active    = pre_act_q;
  assign o_smd_err_cnt   = smd_cnt_q;
  assign o_frag_err_cnt  = frag_cnt_q;

endmodule

// File: tb/tb_qbu_rx_demux.sv
// Self-checking bench for qbu_rx_demux: vector table plus
// hand sequences for fragment, stall and reset corner cases.
module tb_qbu_rx_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_last = 1'b0;
  logic        rx_ready;
  logic [7:0]  rx_smd = '0;
  logic        rx_smd_vld = 1'b0;
  logic [7:0]  rx_fra = '0;
  logic        rx_fra_vld = 1'b0;
  logic        rx_crc = 1'b0;
  logic        rx_mcrc = 1'b0;
  logic        pen = 1'b1;
  logic [7:0]  e_data, p_data;
  logic        e_vld, e_last, e_err, e_rdy;
  logic        p_vld, p_last, p_err, p_abort, p_rdy;
  logic        ver, rsp, pre_act;
  logic [15:0] smd_cnt, frag_cnt;

  always #5 clk = ~clk;

  qbu_rx_demux #(.AXIS_DATA_WIDTH(8)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_mac_rx_data   (rx_data),
    .i_mac_rx_valid  (rx_valid),
    .i_mac_rx_last   (rx_last),
    .o_mac_rx_ready  (rx_ready),
    .i_mac_rx_smd    (rx_smd),
    .i_mac_rx_smd_vld(rx_smd_vld),
    .i_mac_rx_fra    (rx_fra),
    .i_mac_rx_fra_vld(rx_fra_vld),
    .i_mac_rx_crc_ok (rx_crc),
    .i_mac_rx_mcrc   (rx_mcrc),
    .i_preempt_en    (pen),
    .o_emac_rx_data  (e_data),
    .o_emac_rx_valid (e_vld),
    .o_emac_rx_last  (e_last),
    .o_emac_rx_err   (e_err),
    .i_emac_rx_ready (e_rdy),
    .o_pmac_rx_data  (p_data),
    .o_pmac_rx_valid (p_vld),
    .o_pmac_rx_last  (p_last),
    .o_pmac_rx_err   (p_err),
    .o_pmac_rx_abort (p_abort),
    .i_pmac_rx_ready (p_rdy),
    .o_verify_rcv    (ver),
    .o_respond_rcv   (rsp),
    .o_pre_active    (pre_act),
    .o_smd_err_cnt   (smd_cnt),
    .o_frag_err_cnt  (frag_cnt)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       e;
  } beat_t;

  typedef struct {
    logic [7:0] smd;
    logic       sv;
    logic [7:0] fra;
    logic       fv;
    int         n;
    logic       crc;
    logic       mc;
    logic       pen;
    int         dst;
    int         dsmd;
    int         dfrag;
    int         dver;
    int         drsp;
  } vec_t;

  localparam int D_EXP  = 0;
  localparam int D_PRE  = 1;
  localparam int D_NONE = 2;

  beat_t      eq[$];
  beat_t      pq[$];
  int         errors = 0;
  int         checks = 0;
  int         n_ver = 0;
  int         n_rsp = 0;
  int         n_abort = 0;
  int         n_plast = 0;
  logic [7:0] seed = 8'h10;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] smd, input logic sv,
                            input logic [7:0] fra, input logic fv,
                            input int n, input logic crc,
                            input logic mc, input int dst,
                            input int stop_at);
    int    k;
    beat_t b;
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) break;
      rx_valid   = 1'b1;
      rx_data    = seed;
      rx_last    = (i == n - 1);
      rx_smd     = (i == 0) ? smd : 8'h00;
      rx_smd_vld = (i == 0) ? sv : 1'b0;
      rx_fra     = (i == 0) ? fra : 8'h00;
      rx_fra_vld = (i == 0) ? fv : 1'b0;
      rx_crc     = rx_last ? crc : 1'b0;
      rx_mcrc    = rx_last ? mc : 1'b0;
      k = 0;
      @(negedge clk);
      while (!rx_ready && k < 1000) begin
        k++;
        @(negedge clk);
      end
      if (k >= 1000) begin
        chk("rdy_timeout", 0, 1);
      end else begin
        b.d = seed;
        if (dst == D_EXP) begin
          b.l = rx_last;
          b.e = rx_last && !crc;
          eq.push_back(b);
        end else if (dst == D_PRE) begin
          b.l = rx_last && !mc;
          b.e = rx_last && !mc && !crc;
          pq.push_back(b);
        end
      end
      seed++;
      @(posedge clk);
      #1;
    end
    rx_valid   = 1'b0;
    rx_last    = 1'b0;
    rx_smd_vld = 1'b0;
    rx_fra_vld = 1'b0;
    rx_crc     = 1'b0;
    rx_mcrc    = 1'b0;
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      if (e_vld && e_rdy) begin
        if (eq.size() == 0) begin
          chk("emac_unexpected", {e_data, e_last, e_err}, 0);
        end else begin
          b = eq.pop_front();
          chk("emac_beat", {e_data, e_last, e_err}, b);
        end
      end
      if (p_vld && p_rdy) begin
        if (p_last) n_plast++;
        if (pq.size() == 0) begin
          chk("pmac_unexpected", {p_data, p_last, p_err}, 0);
        end else begin
          b = pq.pop_front();
          chk("pmac_beat", {p_data, p_last, p_err}, b);
        end
      end
      if (ver)     n_ver++;
      if (rsp)     n_rsp++;
      if (p_abort) n_abort++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[14];
  int   s0, f0, v0, r0, a0, l0;

  initial begin
    e_rdy = 1'b1;
    p_rdy = 1'b1;

    tbl[0]  = '{8'hD5, 1, 8'h00, 0,  64, 1, 0, 1, D_EXP,  0, 0, 0, 0};
    tbl[1]  = '{8'hD5, 1, 8'h00, 0,   5, 0, 0, 0, D_EXP,  0, 0, 0, 0};
    tbl[2]  = '{8'h07, 1, 8'h00, 0,  60, 1, 0, 1, D_NONE, 0, 0, 1, 0};
    tbl[3]  = '{8'h19, 1, 8'h00, 0,  59, 1, 0, 1, D_NONE, 0, 0, 0, 0};
    tbl[4]  = '{8'h19, 1, 8'h00, 0,  60, 1, 0, 0, D_NONE, 0, 0, 0, 1};
    tbl[5]  = '{8'h07, 1, 8'h00, 0,  60, 0, 0, 1, D_NONE, 0, 0, 0, 0};
    tbl[6]  = '{8'h07, 1, 8'h00, 0, 130, 1, 0, 1, D_NONE, 0, 0, 0, 0};
    tbl[7]  = '{8'h07, 1, 8'h00, 0,  61, 1, 0, 1, D_NONE, 0, 0, 0, 0};
    tbl[8]  = '{8'h33, 1, 8'h00, 0,   5, 1, 0, 1, D_NONE, 1, 0, 0, 0};
    tbl[9]  = '{8'hD5, 0, 8'h00, 0,   4, 1, 0, 1, D_NONE, 1, 0, 0, 0};
    tbl[10] = '{8'hE6, 1, 8'h00, 0,   6, 1, 0, 0, D_NONE, 1, 0, 0, 0};
    tbl[11] = '{8'h7F, 1, 8'h00, 0,   6, 1, 0, 1, D_PRE,  0, 0, 0, 0};
    tbl[12] = '{8'h61, 1, 8'hE6, 1,   4, 1, 0, 1, D_NONE, 0, 1, 0, 0};
    tbl[13] = '{8'hB3, 1, 8'h00, 0,   5, 0, 0, 1, D_PRE,  0, 0, 0, 0};

    @(negedge clk);
    chk("rst_emac_vld", e_vld, 0);
    chk("rst_pmac_vld", p_vld, 0);
    chk("rst_pulses", {p_abort, ver, rsp, pre_act}, 0);
    chk("rst_cnts", {smd_cnt, frag_cnt}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    for (int i = 0; i < 14; i++) begin
      s0  = smd_cnt;
      f0  = frag_cnt;
      v0  = n_ver;
      r0  = n_rsp;
      pen = tbl[i].pen;
      idle(2);
      send_frame(tbl[i].smd, tbl[i].sv, tbl[i].fra, tbl[i].fv,
                 tbl[i].n, tbl[i].crc, tbl[i].mc, tbl[i].dst, -1);
      idle(6);
      chk($sformatf("v%0d_drain", i), eq.size() + pq.size(), 0);
      chk($sformatf("v%0d_smd_err", i), smd_cnt - s0, tbl[i].dsmd);
      chk($sformatf("v%0d_frag_err", i), frag_cnt - f0, tbl[i].dfrag);
      chk($sformatf("v%0d_verify", i), n_ver - v0, tbl[i].dver);
      chk($sformatf("v%0d_respond", i), n_rsp - r0, tbl[i].drsp);
      chk($sformatf("v%0d_pre_active", i), pre_act, 0);
    end
    chk("tbl_no_abort", n_abort, 0);

    // Express frame between two fragments of one preemptable frame
    pen = 1'b1;
    a0 = n_abort;
    l0 = n_plast;
    f0 = frag_cnt;
    send_frame(8'h4C, 1, 8'h00, 0, 10, 0, 1, D_PRE, -1);
    idle(2);
    chk("seqB_pre_after_s", pre_act, 1);
    send_frame(8'hD5, 1, 8'h00, 0, 8, 1, 0, D_EXP, -1);
    idle(2);
    chk("seqB_pre_after_e", pre_act, 1);
    send_frame(8'h52, 1, 8'h4C, 1, 6, 1, 0, D_PRE, -1);
    idle(4);
    chk("seqB_pre_end", pre_act, 0);
    chk("seqB_plast", n_plast - l0, 1);
    chk("seqB_abort", n_abort - a0, 0);
    chk("seqB_frag_err", frag_cnt - f0, 0);
    chk("seqB_drain", eq.size() + pq.size(), 0);

    // Wrong frag_count on continuation
    a0 = n_abort;
    f0 = frag_cnt;
    send_frame(8'hE6, 1, 8'h00, 0, 4, 0, 1, D_PRE, -1);
    send_frame(8'h61, 1, 8'h7F, 1, 4, 1, 0, D_NONE, -1);
    idle(4);
    chk("seqC_abort", n_abort - a0, 1);
    chk("seqC_frag_err", frag_cnt - f0, 1);
    chk("seqC_pre", pre_act, 0);
    chk("seqC_drain", eq.size() + pq.size(), 0);

    // New S start while a frame is pending
    a0 = n_abort;
    f0 = frag_cnt;
    send_frame(8'h7F, 1, 8'h00, 0, 3, 0, 1, D_PRE, -1);
    send_frame(8'hB3, 1, 8'h00, 0, 3, 0, 1, D_PRE, -1);
    idle(3);
    chk("seqS_abort", n_abort - a0, 1);
    chk("seqS_frag_err", frag_cnt - f0, 1);
    chk("seqS_pre", pre_act, 1);

    // Preemption disabled while pending
    a0 = n_abort;
    pen = 1'b0;
    idle(4);
    chk("seqD_abort", n_abort - a0, 1);
    chk("seqD_pre", pre_act, 0);
    pen = 1'b1;
    idle(2);

    // Express back-pressure for 10 cycles
    fork
      send_frame(8'hD5, 1, 8'h00, 0, 64, 1, 0, D_EXP, -1);
      begin
        idle(10);
        e_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_in_ready", rx_ready, 0);
        chk("stall_out_vld", e_vld, 1);
        idle(7);
        e_rdy = 1'b1;
      end
    join
    idle(4);
    chk("stall_drain", eq.size(), 0);

    // Reset mid-fragment
    send_frame(8'hE6, 1, 8'h00, 0, 20, 0, 1, D_PRE, 6);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", {e_vld, p_vld}, 0);
    chk("mid_rst_flags", {p_abort, ver, rsp, pre_act}, 0);
    chk("mid_rst_cnts", {smd_cnt, frag_cnt}, 0);
    eq.delete();
    pq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    send_frame(8'h61, 1, 8'h4C, 1, 4, 1, 0, D_NONE, -1);
    idle(4);
    chk("post_rst_frag_err", frag_cnt, 1);
    chk("post_rst_smd_err", smd_cnt, 0);
    chk("post_rst_pre", pre_act, 0);
    chk("post_rst_drain", eq.size() + pq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
